// File: rtl/ccu_pkg.sv
// Shared types and defaults for the ccu timing generator and its G1 gate flip-flop.
package ccu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } ccu_state_e;

  localparam int CCU_DIGITS    = 36;
  localparam int CCU_PHASES    = 2;
  localparam int CCU_MID_DIGIT = 18;

  // Phase index width; a two-phase (odd/even) rotation still needs one bit.
  function automatic int ccu_phase_width(input int phases);
    return (phases <= 2) ? 1 : $clog2(phases);
  endfunction

endpackage

// File: rtl/ccu_g1_ff.sv
// G1 gate flip-flop: set/clear state with complementary output and a copy delayed by one digit.
module ccu_g1_ff (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic set_i,
  input  logic clr_i,
  output logic g1_pos_o,
  output logic g1_neg_o,
  output logic g1_dz_o
);

  logic g1_pos_q, g1_pos_d;
  logic g1_neg_q;
  logic g1_dz_q, g1_dz_d;

  // Set and clear are qualified by different digits, so they never compete.
  always_comb begin
    g1_pos_d = g1_pos_q;
    g1_dz_d  = g1_dz_q;
    if (set_i) begin
      g1_pos_d = 1'b1;
    end else if (clr_i) begin
      g1_pos_d = 1'b0;
    end else begin
      g1_pos_d = g1_pos_q;
    end
    if (en_i) begin
      g1_dz_d = g1_pos_q;
    end else begin
      g1_dz_d = g1_dz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_pos_q <= 1'b0;
      g1_neg_q <= 1'b1;
      g1_dz_q  <= 1'b0;
    end else begin
      g1_pos_q <= g1_pos_d;
      g1_neg_q <= ~g1_pos_d;
      g1_dz_q  <= g1_dz_d;
    end
  end

  assign g1_pos_o = g1_pos_q;
  assign g1_neg_o = g1_neg_q;
  assign g1_dz_o  = g1_dz_q;

endmodule

// File: rtl/ccu_timing_gen.sv
// Control-section timing generator: one-hot digit pulses, phase counter and G1 gate.
// Optional single-step input enabled by defining CCU_SINGLE_STEP_EN.
module ccu_timing_gen
  import ccu_pkg::*;
#(
  parameter int  DIGITS    = CCU_DIGITS,
  parameter int  PHASES    = CCU_PHASES,
  parameter int  MID_DIGIT = CCU_MID_DIGIT,
  localparam int PW        = ccu_phase_width(PHASES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              dy,
  input  logic              da_n,
`ifdef CCU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic [DIGITS-1:0] d,
  output logic              d_mid,
  output logic [PW-1:0]     phase,
  output logic [PHASES-1:0] ph_d0,
  output logic [PHASES-1:0] ph_dlast,
  output logic              running,
  output logic              g1_pos,
  output logic              g1_neg,
  output logic              g1_dz
);

  localparam int                CW       = $clog2(DIGITS);
  localparam logic [CW-1:0]     LAST_CNT = CW'(DIGITS - 1);
  localparam logic [PW-1:0]     LAST_PH  = PW'(PHASES - 1);
  localparam logic [DIGITS-1:0] D_ONE    = {{(DIGITS - 1){1'b0}}, 1'b1};

  ccu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [DIGITS-1:0] d_q, d_d;
  logic              d_mid_q, d_mid_d;
  logic [PHASES-1:0] ph_d0_q, ph_d0_d;
  logic [PHASES-1:0] ph_dlast_q, ph_dlast_d;
  logic              running_q, running_d;
  logic              g1_set_s, g1_clr_s;

  // Next state plus every output computed from it, so all outputs leave a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    d_d        = '0;
    d_mid_d    = 1'b0;
    ph_d0_d    = '0;
    ph_dlast_d = '0;
    running_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run) begin
          state_d = RUN;
`ifdef CCU_SINGLE_STEP_EN
        end else if (step) begin
          state_d = STEP;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN, STEP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
          // A stop only takes effect at the minor-cycle boundary.
          if (run) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    running_d = (state_d != IDLE);
    if (running_d) begin
      d_d = D_ONE << cnt_d;
    end else begin
      d_d = '0;
    end
    d_mid_d = d_d[MID_DIGIT];
    for (int p = 0; p < PHASES; p++) begin
      ph_d0_d[p]    = d_d[0] & (phase_d == PW'(p));
      ph_dlast_d[p] = d_d[DIGITS-1] & (phase_d == PW'(p));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= '0;
      d_q        <= '0;
      d_mid_q    <= 1'b0;
      ph_d0_q    <= '0;
      ph_dlast_q <= '0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      d_q        <= d_d;
      d_mid_q    <= d_mid_d;
      ph_d0_q    <= ph_d0_d;
      ph_dlast_q <= ph_dlast_d;
      running_q  <= running_d;
    end
  end

  assign g1_set_s = d_q[0] & dy;
  assign g1_clr_s = d_q[DIGITS-1] & ~da_n;

  ccu_g1_ff u_g1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (running_q),
    .set_i    (g1_set_s),
    .clr_i    (g1_clr_s),
    .g1_pos_o (g1_pos),
    .g1_neg_o (g1_neg),
    .g1_dz_o  (g1_dz)
  );

  assign d        = d_q;
  assign d_mid    = d_mid_q;
  assign phase    = phase_q;
  assign ph_d0    = ph_d0_q;
  assign ph_dlast = ph_dlast_q;
  assign running  = running_q;

endmodule

// File: tb/tb_ccu_timing_gen.sv
// Scoreboard bench for ccu_timing_gen: default 36x2 instance plus an 8x3 instance.
module tb_ccu_timing_gen;

  logic clk = 1'b0;
  logic rst_n, run, dy, da_n, run_b;
`ifdef CCU_SINGLE_STEP_EN
  logic step;
`endif

  logic [35:0] d;
  logic        d_mid, running, g1_pos, g1_neg, g1_dz;
  logic [0:0]  phase;
  logic [1:0]  ph_d0, ph_dlast;

  logic [7:0]  d_b;
  logic        d_mid_b, running_b, g1_pos_b, g1_neg_b, g1_dz_b;
  logic [1:0]  phase_b;
  logic [2:0]  ph_d0_b, ph_dlast_b;

  typedef struct {
    int dig;
    int ph;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ccu_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .run(run), .dy(dy), .da_n(da_n),
`ifdef CCU_SINGLE_STEP_EN
    .step(step),
`endif
    .d(d), .d_mid(d_mid), .phase(phase), .ph_d0(ph_d0), .ph_dlast(ph_dlast),
    .running(running), .g1_pos(g1_pos), .g1_neg(g1_neg), .g1_dz(g1_dz)
  );

  ccu_timing_gen #(.DIGITS(8), .PHASES(3), .MID_DIGIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .dy(dy), .da_n(da_n),
`ifdef CCU_SINGLE_STEP_EN
    .step(1'b0),
`endif
    .d(d_b), .d_mid(d_mid_b), .phase(phase_b), .ph_d0(ph_d0_b), .ph_dlast(ph_dlast_b),
    .running(running_b), .g1_pos(g1_pos_b), .g1_neg(g1_neg_b), .g1_dz(g1_dz_b)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_digits(input int ph, input int count);
    exp_t e;
    for (int k = 0; k < count; k++) begin
      e.dig = k;
      e.ph  = ph;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every produced digit pulse is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    logic [63:0] one;
    one = 64'd1;
    chk("g1_complement", {63'd0, g1_neg}, {63'd0, ~g1_pos});
    if (running) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got d=%0h expected no pulse at %0t", d, $time);
      end else begin
        e = exp_q.pop_front();
        chk("digit", {28'd0, d}, one << e.dig);
        chk("phase", {63'd0, phase}, e.ph);
        chk("d_mid", {63'd0, d_mid}, (e.dig == 18) ? 64'd1 : 64'd0);
        chk("ph_d0", {62'd0, ph_d0}, (e.dig == 0) ? (one << e.ph) : 64'd0);
        chk("ph_dlast", {62'd0, ph_dlast}, (e.dig == 35) ? (one << e.ph) : 64'd0);
      end
    end else begin
      chk("idle_d", {28'd0, d}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] one;
    one   = 64'd1;
    rst_n = 1'b0;
    run   = 1'b0;
    run_b = 1'b0;
    dy    = 1'b0;
    da_n  = 1'b1;
`ifdef CCU_SINGLE_STEP_EN
    step  = 1'b0;
`endif
    tick(3);
    chk("rst_d", {28'd0, d}, 64'd0);
    chk("rst_running", {63'd0, running}, 64'd0);
    chk("rst_phase", {63'd0, phase}, 64'd0);
    chk("rst_g1_pos", {63'd0, g1_pos}, 64'd0);
    chk("rst_g1_neg", {63'd0, g1_neg}, 64'd1);
    chk("rst_g1_dz", {63'd0, g1_dz}, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Free run over three minor cycles, stop requested at d27 of the third.
    run = 1'b1;
    push_digits(0, 36);
    push_digits(1, 36);
    push_digits(0, 36);
    tick(100);
    run = 1'b0;
    tick(15);
    chk("t2_running", {63'd0, running}, 64'd0);
    chk("t2_phase", {63'd0, phase}, 64'd1);
    chk("t2_drained", exp_q.size(), 64'd0);

    // G1 set/clear, then a stop cancelled inside the second minor cycle.
    run = 1'b1;
    push_digits(1, 36);
    push_digits(0, 36);
    push_digits(1, 36);
    tick(1);
    dy = 1'b1;
    tick(1);
    dy = 1'b0;
    chk("t3_g1_set", {63'd0, g1_pos}, 64'd1);
    chk("t3_g1_dz_lag", {63'd0, g1_dz}, 64'd0);
    tick(1);
    chk("t3_g1_dz", {63'd0, g1_dz}, 64'd1);
    tick(33);
    da_n = 1'b0;
    tick(1);
    da_n = 1'b1;
    chk("t3_g1_clr", {63'd0, g1_pos}, 64'd0);
    chk("t3_g1_neg", {63'd0, g1_neg}, 64'd1);
    tick(9);
    run = 1'b0;
    tick(20);
    run = 1'b1;
    tick(16);
    run = 1'b0;
    tick(30);
    chk("t4_running", {63'd0, running}, 64'd0);
    chk("t4_phase", {63'd0, phase}, 64'd0);
    chk("t4_drained", exp_q.size(), 64'd0);

    // Asynchronous reset at d20 of a phase-1 minor cycle.
    run = 1'b1;
    push_digits(0, 36);
    push_digits(1, 21);
    tick(1);
    dy = 1'b1;
    tick(1);
    dy = 1'b0;
    tick(55);
    #2;
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    chk("t1_d", {28'd0, d}, 64'd0);
    chk("t1_phase", {63'd0, phase}, 64'd0);
    chk("t1_running", {63'd0, running}, 64'd0);
    chk("t1_g1_pos", {63'd0, g1_pos}, 64'd0);
    chk("t1_g1_neg", {63'd0, g1_neg}, 64'd1);
    chk("t1_g1_dz", {63'd0, g1_dz}, 64'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("t1_drained", exp_q.size(), 64'd0);

`ifdef CCU_SINGLE_STEP_EN
    // Single step: one minor cycle only, a repeated step mid-cycle is ignored.
    step = 1'b1;
    push_digits(0, 36);
    tick(1);
    step = 1'b0;
    tick(10);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(40);
    chk("t6_running", {63'd0, running}, 64'd0);
    chk("t6_phase", {63'd0, phase}, 64'd1);
    chk("t6_drained", exp_q.size(), 64'd0);
`endif

    // Eight digits, three phases: phase must wrap 2 -> 0.
    run_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      chk("t5_d", {56'd0, d_b}, one << (i % 8));
      chk("t5_phase", {62'd0, phase_b}, (i / 8) % 3);
      chk("t5_d_mid", {63'd0, d_mid_b}, ((i % 8) == 4) ? 64'd1 : 64'd0);
      chk("t5_ph_d0", {61'd0, ph_d0_b}, ((i % 8) == 0) ? (one << ((i / 8) % 3)) : 64'd0);
      chk("t5_ph_dlast", {61'd0, ph_dlast_b}, ((i % 8) == 7) ? (one << ((i / 8) % 3)) : 64'd0);
    end
    run_b = 1'b0;
    tick(3);
    chk("t5_running", {63'd0, running_b}, 64'd0);
    chk("t5_final_phase", {62'd0, phase_b}, 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
